seq_priority_encoder: RTL and testbench
=======================================

// Module: seq_priority_encoder
// PURPOSE
//  Sequential N-to-log2(N) priority encoder; the encode side paired with the decoder blocks.
//  Accepts a WIDTH-bit request vector over valid/ready, scans it CHUNK bits per cycle from
//  bit 0 upward, and returns the index of the lowest set bit plus a found flag over valid/ready.
//  Used where wide vectors must be encoded without a single long combinational priority chain.
// PARAMETERS
//  WIDTH   16  request vector width; must be a multiple of CHUNK and >= 2
//  CHUNK   4   bits examined per SCAN cycle; NCHUNK = WIDTH/CHUNK
//  IW      $clog2(WIDTH)  index width (localparam, not overridable)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  enable     in   1       gates acceptance of new requests only
//  in_valid   in   1       request vector present
//  in_ready   out  1       block can accept a request
//  in_vec     in   WIDTH   request vector; bit 0 = highest priority
//  out_valid  out  1       result present
//  out_ready  in   1       downstream accepts result
//  out_index  out  IW      index of lowest set bit; 0 when out_found=0
//  out_found  out  1       1 if any bit of the request was set
//  out_multi  out  1       more than one bit set (only with ENC_MULTI_DETECT_EN)
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE, chunk ptr 0, latched vector 0; out_valid, out_index,
//    out_found, out_multi = 0; in_ready = 0 while rst high.
//  - FSM states IDLE -> SCAN -> DONE -> IDLE.
//  - IDLE: in_ready = enable. Accept on edge with in_valid & in_ready: latch in_vec,
//    ptr <= 0, go SCAN. in_vec ignored when not accepted.
//  - SCAN: in_ready = 0. Each cycle examine latched chunk [ptr*CHUNK +: CHUNK].
//    Any bit set -> out_index <= ptr*CHUNK + lowest set position in chunk, out_found <= 1, go DONE.
//    None set and ptr < NCHUNK-1 -> ptr <= ptr+1. None set and ptr = NCHUNK-1 ->
//    out_index <= 0, out_found <= 0, go DONE.
//  - Latency: first set bit in chunk k -> out_valid high k+1 cycles after accept edge;
//    all-zero vector -> NCHUNK cycles.
//  - DONE: out_valid = 1; out_index/out_found/out_multi held stable until out_ready=1;
//    on that edge out_valid <= 0, go IDLE. in_ready = 0 in DONE (no overlap of requests);
//    earliest next accept is the cycle after the output handshake.
//  - enable deasserted during SCAN/DONE does not abort; the current request completes.
//  - rst asserted in any state: immediate return to reset values; partial scan discarded,
//    no result emitted.
//  - Outputs are registered; no combinational path from in_* to out_*.
// CONFIGURATION
//  ENC_MULTI_DETECT_EN defined: out_multi port present; at accept, out_multi register
//    <= (popcount(in_vec) > 1), presented with the result in DONE, cleared on reset.
//  ENC_MULTI_DETECT_EN undefined: out_multi port and logic absent; all other timing identical.
// TESTING (WIDTH=16, CHUNK=4)
//  1. Reset, enable=1, in_vec=16'h0000 accepted -> out_valid after 4 cycles,
//     out_found=0, out_index=0.
//  2. in_vec=16'h0008 -> out_valid 1 cycle after accept, out_index=3, out_found=1, out_multi=0.
//  3. in_vec=16'h8000 -> out_valid 4 cycles after accept, out_index=15, out_found=1.
//  4. in_vec=16'h0120 -> out_valid 2 cycles after accept, out_index=5; with macro out_multi=1.
//  5. Result pending, out_ready=0 for 3 cycles -> out_* stable, in_ready=0; out_ready=1 ->
//     out_valid=0 and in_ready=1 next cycle; enable=0 in IDLE -> in_ready=0, no accept.
//  6. rst pulsed during SCAN (in_vec=16'h8000) -> out_valid=0 at once, no result emitted;
//     after release, new request 16'h0002 -> out_index=1 after 1 cycle.

Source files
------------

// File: rtl/seq_priority_encoder_if.sv
// seq_priority_encoder_if: request/result handshake bundle; out_multi exists only with ENC_MULTI_DETECT_EN
interface seq_priority_encoder_if #(
  parameter int WIDTH = 16
);
  localparam int IW = $clog2(WIDTH);
  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IW-1:0]    out_index;
  logic             out_found;
`ifdef ENC_MULTI_DETECT_EN
  logic             out_multi;
`endif
  modport master (
    output enable, in_valid, in_vec, out_ready,
`ifdef ENC_MULTI_DETECT_EN
    input  out_multi,
`endif
    input  in_ready, out_valid, out_index, out_found
  );
  modport slave (
    input  enable, in_valid, in_vec, out_ready,
`ifdef ENC_MULTI_DETECT_EN
    output out_multi,
`endif
    output in_ready, out_valid, out_index, out_found
  );
endinterface

// File: rtl/seq_priority_encoder.sv
// seq_priority_encoder: lowest-set-bit encoder scanning CHUNK bits per cycle; ENC_MULTI_DETECT_EN adds out_multi
module seq_priority_encoder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                  clk,
  input logic                  rst,
  seq_priority_encoder_if.slave bus
);
  localparam int IW     = $clog2(WIDTH);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int PW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam int CW     = CHUNK > 1 ? $clog2(CHUNK) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t           state;
  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] vec;
  logic             valid_q;
  logic [IW-1:0]    index_q;
  logic             found_q;
  logic [CHUNK-1:0] chunk;
  logic             hit;
  logic [CW-1:0]    pos;
  logic [IW-1:0]    base;
  assign chunk        = vec[ptr*CHUNK +: CHUNK];
  assign base         = IW'(ptr) * IW'(CHUNK);
  assign bus.in_ready = ~rst & (state == IDLE) & bus.enable;
  assign bus.out_valid = valid_q;
  assign bus.out_index = index_q;
  assign bus.out_found = found_q;
  // descending walk so the lowest set bit wins
  always_comb begin
    hit = 1'b0;
    pos = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) begin
        hit = 1'b1;
        pos = CW'(i);
      end
    end
  end
`ifdef ENC_MULTI_DETECT_EN
  logic multi_q;
  assign bus.out_multi = multi_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) multi_q <= 1'b0;
    else if (bus.in_valid & bus.in_ready) multi_q <= $countones(bus.in_vec) > 1;
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      vec     <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      found_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid & bus.in_ready) begin
          vec   <= bus.in_vec;
          ptr   <= '0;
          state <= SCAN;
        end
        SCAN: if (hit) begin
          index_q <= base + IW'(pos);
          found_q <= 1'b1;
          valid_q <= 1'b1;
          state   <= DONE;
        end else if (ptr == PW'(NCHUNK - 1)) begin
          index_q <= '0;
          found_q <= 1'b0;
          valid_q <= 1'b1;
          state   <= DONE;
        end else begin
          ptr <= ptr + PW'(1);
        end
        DONE: if (bus.out_ready) begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_priority_encoder.sv
// tb_seq_priority_encoder: directed vector table plus handshake, enable and reset corner sequences
module tb_seq_priority_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  seq_priority_encoder_if #(.WIDTH(16)) bus ();
  seq_priority_encoder #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] vec;
    int          idx;
    int          found;
    int          multi;
    int          lat;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [15:0] v);
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    step();
    bus.in_valid = 1'b0;
    bus.in_vec   = 16'hA5A5;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask
  task automatic run(input vec_t t, input string tag);
    int lat;
    accept(t.vec);
    wait_out(lat);
    chk({tag, "_latency"}, lat, t.lat);
    chk({tag, "_index"}, int'(bus.out_index), t.idx);
    chk({tag, "_found"}, int'(bus.out_found), t.found);
`ifdef ENC_MULTI_DETECT_EN
    chk({tag, "_multi"}, int'(bus.out_multi), t.multi);
`endif
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, int'(bus.out_valid), 0);
  endtask
  initial begin
    int lat;
    tbl[0] = '{16'h0000,  0, 0, 0, 4};
    tbl[1] = '{16'h0008,  3, 1, 0, 1};
    tbl[2] = '{16'h8000, 15, 1, 0, 4};
    tbl[3] = '{16'h0120,  5, 1, 1, 2};
    tbl[4] = '{16'h0001,  0, 1, 0, 1};
    tbl[5] = '{16'h00F0,  4, 1, 1, 2};
    tbl[6] = '{16'h0C00, 10, 1, 1, 3};
    tbl[7] = '{16'hFFFF,  0, 1, 1, 1};
    tbl[8] = '{16'h0010,  4, 1, 0, 2};
    tbl[9] = '{16'h4000, 14, 1, 0, 4};
    bus.enable    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_index", int'(bus.out_index), 0);
    chk("rst_out_found", int'(bus.out_found), 0);
`ifdef ENC_MULTI_DETECT_EN
    chk("rst_out_multi", int'(bus.out_multi), 0);
`endif
    #2 rst = 1'b0;
    step();
    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));
    // held result: outputs stable and no new accept while out_ready is low
    accept(16'h0040);
    wait_out(lat);
    chk("hold_latency", lat, 2);
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_index", int'(bus.out_index), 6);
      chk("hold_found", int'(bus.out_found), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.enable = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("release_valid", int'(bus.out_valid), 0);
    chk("release_in_ready", int'(bus.in_ready), 1);
    bus.enable = 1'b0;
    #1;
    chk("disabled_in_ready", int'(bus.in_ready), 0);
    bus.in_valid = 1'b1;
    bus.in_vec   = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("disabled_no_result", int'(bus.out_valid), 0);
      chk("disabled_in_ready_hold", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.enable = 1'b1;
    #1;
    // enable dropped mid-scan must not abort the request
    accept(16'h8000);
    bus.enable = 1'b0;
    wait_out(lat);
    chk("noabort_latency", lat, 4);
    chk("noabort_index", int'(bus.out_index), 15);
    bus.enable = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    accept(16'h8000);
    step();
    rst = 1'b1;
    #1;
    chk("midscan_rst_valid", int'(bus.out_valid), 0);
    chk("midscan_rst_in_ready", int'(bus.in_ready), 0);
    chk("midscan_rst_index", int'(bus.out_index), 0);
    step();
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("after_rst_no_result", int'(bus.out_valid), 0);
    end
    run('{16'h0002, 1, 1, 0, 1}, "post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
